// File: rtl/stream_fifo_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : stream_fifo_rr_arbiter
// Brief   : Two-input burst-granular round-robin arbiter that feeds a single
//           StreamingFIFO input. Intake is throttled on FIFO occupancy, and an
//           occupancy high-watermark is kept for depth tuning.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module stream_fifo_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 14,
  parameter int FIFO_DEPTH = 16384,
  parameter int HEADROOM   = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [WIDTH-1:0]     in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  input  logic [WIDTH-1:0]     in1_V_V_TDATA,
  input  logic                 in1_V_V_TVALID,
  output logic                 in1_V_V_TREADY,
  output logic [WIDTH-1:0]     out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY,
  input  logic [CNT_WIDTH-1:0] fifo_count,
  input  logic                 clr_max,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] max_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  // Throttle threshold is one bit wider than the count so it can never wrap.
  localparam logic [CNT_WIDTH:0] THRESH    = (CNT_WIDTH+1)'(FIFO_DEPTH - HEADROOM);
  localparam logic [15:0]        LAST_BEAT = 16'(BURST_LEN - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 last_q, last_d;   // index of the last-served producer
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [CNT_WIDTH-1:0] max_q;

  logic             slot_free;
  logic             throttle;
  logic             accept_ok;
  logic             sel_valid;
  logic             sel_idx;
  logic             accept;
  logic [WIDTH-1:0] acc_data;

  assign slot_free = !out_valid_q || out_V_V_TREADY;
  assign throttle  = {1'b0, fifo_count} >= THRESH;
  assign accept_ok = slot_free && !throttle;

  // Source selection: fresh round-robin choice in IDLE, owner only while locked.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in0_V_V_TVALID && in1_V_V_TVALID) begin
          sel_valid = 1'b1;
          sel_idx   = ~last_q;
        end else if (in0_V_V_TVALID) begin
          sel_valid = 1'b1;
          sel_idx   = 1'b0;
        end else if (in1_V_V_TVALID) begin
          sel_valid = 1'b1;
          sel_idx   = 1'b1;
        end
      end
      LOCK0: begin
        sel_valid = 1'b1;
        sel_idx   = 1'b0;
      end
      LOCK1: begin
        sel_valid = 1'b1;
        sel_idx   = 1'b1;
      end
      default: begin
        sel_valid = 1'b0;
        sel_idx   = 1'b0;
      end
    endcase
  end

  // Readies are gated by reset so neither producer can transfer while held.
  assign in0_V_V_TREADY = ap_rst_n && accept_ok && sel_valid && !sel_idx;
  assign in1_V_V_TREADY = ap_rst_n && accept_ok && sel_valid &&  sel_idx;

  assign accept   = sel_idx ? (in1_V_V_TVALID && in1_V_V_TREADY)
                            : (in0_V_V_TVALID && in0_V_V_TREADY);
  assign acc_data = sel_idx ? in1_V_V_TDATA : in0_V_V_TDATA;

  // Next-state logic: lock on the first beat, release after BURST_LEN beats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (BURST_LEN == 1) begin
            last_d = sel_idx;
          end else begin
            state_d = sel_idx ? LOCK1 : LOCK0;
            cnt_d   = 16'd1;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            last_d  = sel_idx;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // One-entry output register: load on accept, otherwise drain on ready.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_data;
    end else if (out_V_V_TREADY) begin
      out_valid_q <= 1'b0;
    end
  end

  // Occupancy high-watermark; clear wins over update.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      max_q <= '0;
    end else if (clr_max) begin
      max_q <= '0;
    end else if (fifo_count > max_q) begin
      max_q <= fifo_count;
    end
  end

  assign out_V_V_TVALID = out_valid_q;
  assign out_V_V_TDATA  = out_data_q;
  assign grant          = {state_q == LOCK1, state_q == LOCK0};
  assign max_count      = max_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_stream_fifo_rr_arbiter
// Brief   : Directed bench for stream_fifo_rr_arbiter (BURST_LEN=16,
//           FIFO_DEPTH=16384, HEADROOM=2). Producer 0 sends idx, producer 1
//           sends 0x80|idx.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_stream_fifo_rr_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [7:0]  in0_data = '0, in1_data = '0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        r0, r1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_rdy = 1'b1;
  logic [13:0] fifo_count = '0;
  logic        clr_max = 1'b0;
  logic [1:0]  grant;
  logic [13:0] max_count;

  int checks = 0;
  int errors = 0;
  int p0_idx = 0;
  int p1_idx = 0;
  logic s_r0, s_r1;
  logic [7:0] drained[$];

  stream_fifo_rr_arbiter #(
    .WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(14), .FIFO_DEPTH(16384), .HEADROOM(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in0_V_V_TDATA(in0_data), .in0_V_V_TVALID(v0), .in0_V_V_TREADY(r0),
    .in1_V_V_TDATA(in1_data), .in1_V_V_TVALID(v1), .in1_V_V_TREADY(r1),
    .out_V_V_TDATA(out_data), .out_V_V_TVALID(out_valid), .out_V_V_TREADY(out_rdy),
    .fifo_count(fifo_count), .clr_max(clr_max),
    .grant(grant), .max_count(max_count)
  );

  always #5 ap_clk = ~ap_clk;

  // Drive producer data for the current indices, then sample the readies.
  task automatic present();
    in0_data = 8'(p0_idx) & 8'h7F;
    in1_data = 8'h80 | 8'(p1_idx);
    #1;
    s_r0 = r0;
    s_r1 = r1;
    if (out_valid && out_rdy) drained.push_back(out_data);
  endtask

  // Advance one clock and account for transferred beats.
  task automatic clock();
    logic a0, a1;
    a0 = v0 && s_r0;
    a1 = v1 && s_r1;
    @(posedge ap_clk);
    if (a0) p0_idx++;
    if (a1) p1_idx++;
    @(negedge ap_clk);
  endtask

  task automatic do_reset();
    v0 = 1'b0; v1 = 1'b0; out_rdy = 1'b1; fifo_count = '0; clr_max = 1'b0;
    p0_idx = 0; p1_idx = 0;
    drained.delete();
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ap_rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 2'b00 || max_count !== 14'd0 ||
        r0 !== 1'b0 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: got valid=%b data=%h grant=%b max=%0d r0=%b r1=%b want 0/00/00/0/0/0",
               out_valid, out_data, grant, max_count, r0, r1);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_single_producer();
    logic [7:0] exp_d;
    do_reset();
    v0 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      present();
      checks++;
      if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin
        errors++;
        $display("FAIL single_ready beat %0d: got r0=%b r1=%b want 1 0", k, s_r0, s_r1);
      end
      checks++;
      if (grant !== ((k % 16 == 0) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL single_grant beat %0d: got %b want %b", k, grant,
                 (k % 16 == 0) ? 2'b00 : 2'b01);
      end
      clock();
      exp_d = 8'(k);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++;
        $display("FAIL single_latency beat %0d: got v=%b d=%h want 1 %h", k, out_valid, out_data, exp_d);
      end
    end
    v0 = 1'b0;
    present(); clock();
    checks++;
    if (drained.size() !== 40) begin
      errors++;
      $display("FAIL single_count: got %0d want 40", drained.size());
    end
    for (int k = 0; k < drained.size() && k < 40; k++) begin
      exp_d = 8'(k);
      checks++;
      if (drained[k] !== exp_d) begin
        errors++;
        $display("FAIL single_order %0d: got %h want %h", k, drained[k], exp_d);
      end
    end
  endtask

  task automatic test_round_robin();
    int i, b, src, idx;
    logic [7:0] exp_d;
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 128; c++) begin
      v0 = (p0_idx < 64);
      v1 = (p1_idx < 64);
      present();
      i = p0_idx + p1_idx;
      b = i / 16;
      src = b % 2;
      exp_g = (i % 16 == 0) ? 2'b00 : ((src == 0) ? 2'b01 : 2'b10);
      checks++;
      if (s_r0 !== (src == 0) || s_r1 !== (src == 1) || grant !== exp_g) begin
        errors++;
        $display("FAIL rr_cycle %0d: got r0=%b r1=%b grant=%b want r0=%b r1=%b grant=%b",
                 c, s_r0, s_r1, grant, src == 0, src == 1, exp_g);
      end
      clock();
    end
    v0 = 1'b0; v1 = 1'b0;
    present(); clock();
    checks++;
    if (drained.size() !== 128) begin
      errors++;
      $display("FAIL rr_count: got %0d want 128", drained.size());
    end
    for (int k = 0; k < drained.size() && k < 128; k++) begin
      b = k / 16;
      idx = (b / 2) * 16 + (k % 16);
      exp_d = (b % 2 == 0) ? 8'(idx) : (8'h80 | 8'(idx));
      checks++;
      if (drained[k] !== exp_d) begin
        errors++;
        $display("FAIL rr_order %0d: got %h want %h", k, drained[k], exp_d);
      end
    end
  endtask

  task automatic test_burst_atomic();
    logic [7:0] exp_d;
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    for (int c = 0; c < 5; c++) begin present(); clock(); end
    v0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      present();
      checks++;
      if (s_r1 !== 1'b0 || grant !== 2'b01) begin
        errors++;
        $display("FAIL atomic_hold %0d: got r1=%b grant=%b want 0 01", c, s_r1, grant);
      end
      clock();
    end
    v0 = 1'b1;
    for (int c = 0; c < 11; c++) begin
      present();
      checks++;
      if (s_r0 !== 1'b1) begin
        errors++;
        $display("FAIL atomic_resume %0d: got r0=%b want 1", c, s_r0);
      end
      clock();
    end
    present();
    checks++;
    if (s_r1 !== 1'b1 || s_r0 !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL atomic_switch: got r0=%b r1=%b grant=%b want 0 1 00", s_r0, s_r1, grant);
    end
    clock();
    present();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL atomic_grant1: got %b want 10", grant);
    end
    clock();
    v0 = 1'b0; v1 = 1'b0;
    present(); clock();
    checks++;
    if (drained.size() !== 18) begin
      errors++;
      $display("FAIL atomic_count: got %0d want 18", drained.size());
    end
    for (int k = 0; k < drained.size() && k < 18; k++) begin
      exp_d = (k < 16) ? 8'(k) : (8'h80 | 8'(k - 16));
      checks++;
      if (drained[k] !== exp_d) begin
        errors++;
        $display("FAIL atomic_order %0d: got %h want %h", k, drained[k], exp_d);
      end
    end
  endtask

  task automatic test_throttle();
    do_reset();
    v0 = 1'b1;
    fifo_count = 14'd16381;
    present();
    checks++;
    if (s_r0 !== 1'b1) begin
      errors++;
      $display("FAIL throttle_16381: got r0=%b want 1", s_r0);
    end
    clock();
    fifo_count = 14'd16382;
    v1 = 1'b1;
    present();
    checks++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL throttle_16382: got r0=%b r1=%b v=%b d=%h want 0 0 1 00",
               s_r0, s_r1, out_valid, out_data);
    end
    clock();
    present();
    checks++;
    if (out_valid !== 1'b0 || drained.size() !== 1 || s_r0 !== 1'b0) begin
      errors++;
      $display("FAIL throttle_drain: got v=%b drained=%0d r0=%b want 0 1 0",
               out_valid, drained.size(), s_r0);
    end
    clock();
  endtask

  task automatic test_backpressure();
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    present(); clock();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      present();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || s_r0 !== 1'b0 || s_r1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall %0d: got v=%b d=%h r0=%b r1=%b want 1 00 0 0",
                 c, out_valid, out_data, s_r0, s_r1);
      end
      clock();
    end
    out_rdy = 1'b1;
    present();
    checks++;
    if (s_r0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got r0=%b want 1", s_r0);
    end
    clock();
    v0 = 1'b0; v1 = 1'b0;
    present(); clock();
    checks++;
    if (drained.size() !== 2 || drained[0] !== 8'h00 || drained[1] !== 8'h01) begin
      errors++;
      $display("FAIL bp_order: got n=%0d first=%h second=%h want 2 00 01", drained.size(),
               (drained.size() > 0) ? drained[0] : 8'hxx, (drained.size() > 1) ? drained[1] : 8'hxx);
    end
  endtask

  task automatic test_watermark();
    logic [13:0] fc[5];
    logic        cl[5];
    logic [13:0] ex[5];
    fc = '{14'd5, 14'd100, 14'd40, 14'd40, 14'd7};
    cl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ex = '{14'd5, 14'd100, 14'd100, 14'd0, 14'd7};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      fifo_count = fc[s];
      clr_max = cl[s];
      present(); clock();
      checks++;
      if (max_count !== ex[s]) begin
        errors++;
        $display("FAIL watermark step %0d: got %0d want %0d", s, max_count, ex[s]);
      end
    end
    clr_max = 1'b0;
    fifo_count = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    fifo_count = 14'd50;
    v0 = 1'b1;
    for (int c = 0; c < 16; c++) begin present(); clock(); end
    fifo_count = '0;
    v0 = 1'b0; v1 = 1'b1;
    for (int c = 0; c < 3; c++) begin present(); clock(); end
    v0 = 1'b1;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 2'b00 || max_count !== 14'd0 ||
        r0 !== 1'b0 || r1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got v=%b d=%h grant=%b max=%0d r0=%b r1=%b want 0 00 00 0 0 0",
               out_valid, out_data, grant, max_count, r0, r1);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    present();
    checks++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL midreset_rearb: got r0=%b r1=%b grant=%b want 1 0 00", s_r0, s_r1, grant);
    end
    clock();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      errors++;
      $display("FAIL midreset_beat: got v=%b d=%h want 1 10", out_valid, out_data);
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    @(negedge ap_clk);
    test_reset();
    test_single_producer();
    test_round_robin();
    test_burst_atomic();
    test_throttle();
    test_backpressure();
    test_watermark();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
